fifo_word_serializer: RTL and testbench
=======================================

Name: fifo_word_serializer

Overview:
- Drain stage directly downstream of the 32-bit expanded-width FIFO.
- Pops one 32-bit word at a time through the FIFO's get/data_out/empty interface.
- Emits each word as BYTE_W-bit bytes, MSB byte first, on a valid/ready byte stream feeding the narrow link/port logic.
- Counts completed words for debug/status.

Parameters:
- WORD_W, 32, FIFO word width; must be an integer multiple of BYTE_W, ratio >= 2.
- BYTE_W, 8, output byte width.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 asserts).
- enable  input  1  allows new FIFO pops; a word already in progress always completes.
- fifo_data  input  WORD_W  FIFO data_out; valid the cycle after a pop.
- fifo_empty  input  1  FIFO empty flag.
- fifo_get  output  1  FIFO pop strobe (drives FIFO get).
- byte_out  output  BYTE_W  current output byte.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- busy  output  1  high in any state other than IDLE.
- words_sent  output  CNT_W  count of fully transmitted words.

Behaviour:
- FIFO contract:
  - A pop is fifo_get=1 while fifo_empty=0, sampled on a clk edge.
  - The popped word appears on fifo_data in the following cycle and is captured at the end of that cycle.
- States: IDLE, WAIT, SEND.
- IDLE:
  - fifo_get = enable && !fifo_empty (combinational).
  - If fifo_get=1, go to WAIT.
- WAIT:
  - Lasts exactly one cycle; fifo_get=0.
  - At the end of the cycle, shreg <= fifo_data, byte_cnt <= 0; go to SEND.
- SEND:
  - byte_valid=1; byte_out = shreg[WORD_W-1 -: BYTE_W].
  - On byte_valid && byte_ready: shreg shifts left by BYTE_W and byte_cnt increments.
  - While byte_ready=0, byte_out and byte_valid hold stable; no shift, no count.
- Last byte (byte_cnt = WORD_W/BYTE_W-1) accepted:
  - words_sent increments, wrapping modulo 2^CNT_W.
  - If enable && !fifo_empty in that same cycle: fifo_get=1 (combinational) and go to WAIT. This back-to-back pop gives a 1-cycle gap with byte_valid=0 between words.
  - Otherwise go to IDLE.
- fifo_get is never 1 when fifo_empty=1.
- fifo_get is never 1 in WAIT, or in SEND outside the last-byte handshake cycle.
- byte_valid=0 in IDLE and WAIT.
- Latency: a pop at edge N, capture at edge N+1, first byte valid in cycle N+1..N+2, i.e. 2 cycles from fifo_get to byte_valid.
- Throughput: with byte_ready held at 1, WORD_W/BYTE_W+1 cycles per word.
- enable deasserted mid-word: the current word finishes, then the block returns to IDLE with no further pop.
- fifo_empty toggling during SEND is ignored until the last-byte cycle.
- Reset:
  - Any state, any time: state=IDLE, shreg=0, byte_cnt=0, words_sent=0.
  - Outputs go immediately to fifo_get=0, byte_valid=0, byte_out=0, busy=0.
  - A word popped but not fully sent is discarded (not re-read).
  - After reset release, operation restarts from IDLE on the next edge.
- No X propagation: byte_out is 0 whenever byte_valid=0 (shreg is cleared in IDLE).

Test Plan:
1. Reset then single word:
   - Stimulus: reset=0 for 20 ns, release; FIFO holds 0x11223344; enable=1, byte_ready=1.
   - Required: exactly one fifo_get pulse; bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles; words_sent=1; busy then drops; no further fifo_get while empty.
2. Back-to-back words:
   - Stimulus: FIFO holds 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC.
   - Required: 12 bytes AA×4, BB×4, CC×4, with a 1-cycle byte_valid=0 gap between words; three fifo_get pulses, each coincident with a last-byte handshake (except the first); words_sent=3.
3. Backpressure:
   - Stimulus: word 0xDEADBEEF, byte_ready low for 3 cycles on byte 0xAD.
   - Required: 0xAD held stable with byte_valid=1 for 4 cycles; sequence DE, AD, BE, EF is intact; no extra pop.
4. enable drop mid-word:
   - Stimulus: FIFO holds 2 words; deassert enable after the first byte.
   - Required: first word completes all 4 bytes; no second fifo_get until enable=1 again, then the second word is sent normally.
5. Reset mid-operation:
   - Stimulus: assert reset while byte 2 of 0x01020304 is presented.
   - Required: byte_valid, fifo_get, busy go 0 and words_sent=0 immediately (asynchronously); after release the next FIFO word is sent from its MSB byte; 0x03/0x04 are never emitted.
6. Empty guard and counter wrap:
   - Stimulus: hold fifo_empty=1 with enable=1 for 50 cycles; then, with CNT_W=2, send 5 words.
   - Required: fifo_get stays 0 throughout the empty period; words_sent reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fifo_word_serializer_if.sv
// Signal bundle tying the serializer to its source FIFO and to the byte sink.
interface fifo_word_serializer_if #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
);
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_get;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;

  // Serializer side: pops the FIFO and drives the byte stream.
  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  byte_ready,
    output fifo_get,
    output byte_out,
    output byte_valid
  );

  // Environment side: the FIFO plus the byte consumer.
  modport slave (
    output fifo_data,
    output fifo_empty,
    output byte_ready,
    input  fifo_get,
    input  byte_out,
    input  byte_valid
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains the wide FIFO one word at a time and emits it MSB byte first on a
// valid/ready byte stream; also counts fully transmitted words.
//
// state  | meaning
// S_IDLE | nothing in flight; pops when enabled and FIFO not empty
// S_WAIT | popped word is on fifo_data this cycle; captured at the edge
// S_SEND | presenting bytes of the captured word; pops again on last accept
//
// WORD_W must be an integer multiple of BYTE_W with at least two bytes/word.
module fifo_word_serializer #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  fifo_word_serializer_if.master bus,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_words_sent
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int BC_W   = $clog2(NBYTES);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_shreg;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]  r_words_sent;
  logic              w_can_pop;
  logic              w_accept;
  logic              w_last_hs;
  logic              w_get;

  // Reset is folded into the pop qualifier so fifo_get drops the instant
  // reset asserts, even though the state register already reads IDLE.
  assign w_can_pop = i_enable && !bus.fifo_empty && reset;
  assign w_accept  = (r_state == S_SEND) && bus.byte_ready;
  assign w_last_hs = w_accept && (r_byte_cnt == LAST_IDX);

  // Next-state and pop strobe.
  always_comb begin
    w_state_next = r_state;
    w_get        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_get        = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_last_hs) begin
          if (w_can_pop) begin
            w_get        = 1'b1;
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the popped word, then shift one byte out per accepted handshake.
  // Holding shreg at zero in IDLE keeps byte_out at 0 whenever not valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_shreg    <= bus.fifo_data;
          r_byte_cnt <= '0;
        end
        S_SEND: begin
          if (w_accept) begin
            r_shreg    <= r_shreg << BYTE_W;
            r_byte_cnt <= w_last_hs ? '0 : r_byte_cnt + BC_W'(1);
          end
        end
        default: begin
          r_shreg    <= '0;
          r_byte_cnt <= '0;
        end
      endcase
    end
  end

  // Completed-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_words_sent <= '0;
    end else if (w_last_hs) begin
      r_words_sent <= r_words_sent + CNT_W'(1);
    end
  end

  assign bus.fifo_get   = w_get;
  assign bus.byte_valid = (r_state == S_SEND);
  assign bus.byte_out   = r_shreg[WORD_W-1 -: BYTE_W];
  assign o_busy         = (r_state != S_IDLE);
  assign o_words_sent   = r_words_sent;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer with a behavioural FIFO and a
// byte/pop recorder. Counter width is shrunk to 2 bits to exercise wrap.
module tb_fifo_word_serializer;
  localparam int WW = 32;
  localparam int BW = 8;
  localparam int CW = 2;
  localparam int NB = WW / BW;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic          enable = 1'b0;
  logic          busy;
  logic [CW-1:0] words_sent;

  int n_checks = 0;
  int n_errors = 0;

  fifo_word_serializer_if #(.WORD_W(WW), .BYTE_W(BW)) bus ();

  fifo_word_serializer #(.WORD_W(WW), .BYTE_W(BW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .bus          (bus),
    .o_busy       (busy),
    .o_words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data_out registered one cycle after a pop.
  logic [WW-1:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign bus.fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (bus.fifo_get && !bus.fifo_empty) begin
      bus.fifo_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  // Recorder: accepted bytes, pop cycles and protocol violations.
  int cyc  = 0;
  int bidx = 0;
  int viol = 0;
  logic [BW-1:0] acc_b [$];
  int            acc_c [$];
  int            pop_c [$];
  always @(posedge clk) begin
    if (reset) begin
      if (bus.fifo_get) pop_c.push_back(cyc);
      if (bus.fifo_get && bus.fifo_empty) viol++;
      if (bus.fifo_get && bus.byte_valid && !(bus.byte_ready && bidx == NB - 1)) viol++;
      if (!bus.byte_valid && bus.byte_out != '0) viol++;
      if (bus.byte_valid && bus.byte_ready) begin
        acc_b.push_back(bus.byte_out);
        acc_c.push_back(cyc);
        bidx = (bidx + 1) % NB;
      end
    end else begin
      bidx = 0;
    end
    cyc++;
  end

  function automatic logic [BW-1:0] bq(input int i);
    return (i < acc_b.size()) ? acc_b[i] : 8'h00;
  endfunction

  function automatic int cq(input int i);
    return (i < acc_c.size()) ? acc_c[i] : -1;
  endfunction

  function automatic int pq(input int i);
    return (i < pop_c.size()) ? pop_c[i] : -1;
  endfunction

  task automatic push(input logic [WW-1:0] w);
    mem[wp] = w;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    enable = 1'b0;
    reset  = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0b, expected 0", busy); end
    n_checks++; if (words_sent !== 2'd0) begin n_errors++; $display("FAIL rst_words: got %0d, expected 0", words_sent); end
    n_checks++; if (bus.byte_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b, expected 0", bus.byte_valid); end
    repeat (2) @(posedge clk);
    #4 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; bus.byte_ready = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL init_busy: got %0b, expected 0", busy); end
    n_checks++; if (bus.byte_valid !== 1'b0) begin n_errors++; $display("FAIL init_valid: got %0b, expected 0", bus.byte_valid); end
    n_checks++; if (bus.fifo_get !== 1'b0) begin n_errors++; $display("FAIL init_get: got %0b, expected 0", bus.fifo_get); end
    n_checks++; if (bus.byte_out !== 8'h00) begin n_errors++; $display("FAIL init_byte: got %0h, expected 0", bus.byte_out); end
    n_checks++; if (words_sent !== 2'd0) begin n_errors++; $display("FAIL init_words: got %0d, expected 0", words_sent); end
    #19 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int b0 = acc_b.size();
    int p0 = pop_c.size();
    logic [BW-1:0] e [0:3];
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    push(32'h11223344);
    enable = 1'b1;
    repeat (16) @(posedge clk); #1;
    n_checks++; if (pop_c.size() - p0 !== 1) begin n_errors++; $display("FAIL single_pops: got %0d, expected 1", pop_c.size() - p0); end
    n_checks++; if (acc_b.size() - b0 !== 4) begin n_errors++; $display("FAIL single_nbytes: got %0d, expected 4", acc_b.size() - b0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bq(b0 + i) !== e[i]) begin n_errors++; $display("FAIL single_byte%0d: got %0h, expected %0h", i, bq(b0 + i), e[i]); end
      n_checks++; if (cq(b0 + i) !== pq(p0) + 2 + i) begin n_errors++; $display("FAIL single_cycle%0d: got %0d, expected %0d", i, cq(b0 + i), pq(p0) + 2 + i); end
    end
    n_checks++; if (words_sent !== 2'd1) begin n_errors++; $display("FAIL single_words: got %0d, expected 1", words_sent); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy: got %0b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int b0, p0;
    logic [BW-1:0] e [0:2];
    e = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    b0 = acc_b.size();
    p0 = pop_c.size();
    push(32'hAAAAAAAA); push(32'hBBBBBBBB); push(32'hCCCCCCCC);
    enable = 1'b1;
    repeat (25) @(posedge clk); #1;
    n_checks++; if (pop_c.size() - p0 !== 3) begin n_errors++; $display("FAIL b2b_pops: got %0d, expected 3", pop_c.size() - p0); end
    n_checks++; if (acc_b.size() - b0 !== 12) begin n_errors++; $display("FAIL b2b_nbytes: got %0d, expected 12", acc_b.size() - b0); end
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (bq(b0 + i) !== e[i / 4]) begin n_errors++; $display("FAIL b2b_byte%0d: got %0h, expected %0h", i, bq(b0 + i), e[i / 4]); end
    end
    for (int i = 1; i < 12; i++) begin
      n_checks++; if (cq(b0 + i) - cq(b0 + i - 1) !== ((i % 4 == 0) ? 2 : 1)) begin n_errors++; $display("FAIL b2b_spacing%0d: got %0d, expected %0d", i, cq(b0 + i) - cq(b0 + i - 1), (i % 4 == 0) ? 2 : 1); end
    end
    n_checks++; if (pq(p0 + 1) !== cq(b0 + 3)) begin n_errors++; $display("FAIL b2b_pop2_cycle: got %0d, expected %0d", pq(p0 + 1), cq(b0 + 3)); end
    n_checks++; if (pq(p0 + 2) !== cq(b0 + 7)) begin n_errors++; $display("FAIL b2b_pop3_cycle: got %0d, expected %0d", pq(p0 + 2), cq(b0 + 7)); end
    n_checks++; if (words_sent !== 2'd3) begin n_errors++; $display("FAIL b2b_words: got %0d, expected 3", words_sent); end
  endtask

  task automatic test_backpressure();
    int b0, p0;
    bit found = 0;
    logic [BW-1:0] e [0:3];
    e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    b0 = acc_b.size();
    p0 = pop_c.size();
    push(32'hDEADBEEF);
    enable = 1'b1;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.byte_valid && bus.byte_out == 8'hAD) found = 1;
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL bp_reach_ad: got %0b, expected 1", found); end
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'hAD) begin n_errors++; $display("FAIL bp_hold%0d: got valid=%0b byte=%0h, expected valid=1 byte=ad", k, bus.byte_valid, bus.byte_out); end
      if (k < 3) begin @(posedge clk); #1; end
    end
    bus.byte_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    n_checks++; if (acc_b.size() - b0 !== 4) begin n_errors++; $display("FAIL bp_nbytes: got %0d, expected 4", acc_b.size() - b0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bq(b0 + i) !== e[i]) begin n_errors++; $display("FAIL bp_byte%0d: got %0h, expected %0h", i, bq(b0 + i), e[i]); end
    end
    n_checks++; if (cq(b0 + 1) - cq(b0) !== 4) begin n_errors++; $display("FAIL bp_stall_len: got %0d, expected 4", cq(b0 + 1) - cq(b0)); end
    n_checks++; if (pop_c.size() - p0 !== 1) begin n_errors++; $display("FAIL bp_pops: got %0d, expected 1", pop_c.size() - p0); end
    n_checks++; if (words_sent !== 2'd1) begin n_errors++; $display("FAIL bp_words: got %0d, expected 1", words_sent); end
  endtask

  task automatic test_enable_drop();
    int b0, p0;
    logic [BW-1:0] e [0:7];
    e = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_reset();
    b0 = acc_b.size();
    p0 = pop_c.size();
    push(32'h12345678); push(32'h9ABCDEF0);
    enable = 1'b1;
    for (int t = 0; t < 20 && acc_b.size() == b0; t++) begin
      @(posedge clk); #1;
    end
    enable = 1'b0;
    repeat (12) @(posedge clk); #1;
    n_checks++; if (acc_b.size() - b0 !== 4) begin n_errors++; $display("FAIL en_first_nbytes: got %0d, expected 4", acc_b.size() - b0); end
    n_checks++; if (pop_c.size() - p0 !== 1) begin n_errors++; $display("FAIL en_held_pops: got %0d, expected 1", pop_c.size() - p0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL en_idle_busy: got %0b, expected 0", busy); end
    n_checks++; if (words_sent !== 2'd1) begin n_errors++; $display("FAIL en_words1: got %0d, expected 1", words_sent); end
    enable = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_checks++; if (pop_c.size() - p0 !== 2) begin n_errors++; $display("FAIL en_pops: got %0d, expected 2", pop_c.size() - p0); end
    n_checks++; if (acc_b.size() - b0 !== 8) begin n_errors++; $display("FAIL en_nbytes: got %0d, expected 8", acc_b.size() - b0); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bq(b0 + i) !== e[i]) begin n_errors++; $display("FAIL en_byte%0d: got %0h, expected %0h", i, bq(b0 + i), e[i]); end
    end
    n_checks++; if (words_sent !== 2'd2) begin n_errors++; $display("FAIL en_words2: got %0d, expected 2", words_sent); end
  endtask

  // Runs straight after test_enable_drop so words_sent is non-zero going in.
  task automatic test_reset_mid();
    int b0 = acc_b.size();
    int p0 = pop_c.size();
    int stray = 0;
    bit found = 0;
    logic [BW-1:0] e [0:4];
    e = '{8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    push(32'h01020304); push(32'h55667788);
    enable = 1'b1;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.byte_valid && bus.byte_out == 8'h02) found = 1;
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rm_reach_02: got %0b, expected 1", found); end
    #3 reset = 1'b0;
    #1;
    n_checks++; if (bus.byte_valid !== 1'b0) begin n_errors++; $display("FAIL rm_valid: got %0b, expected 0", bus.byte_valid); end
    n_checks++; if (bus.fifo_get !== 1'b0) begin n_errors++; $display("FAIL rm_get: got %0b, expected 0", bus.fifo_get); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %0b, expected 0", busy); end
    n_checks++; if (words_sent !== 2'd0) begin n_errors++; $display("FAIL rm_words: got %0d, expected 0", words_sent); end
    n_checks++; if (bus.byte_out !== 8'h00) begin n_errors++; $display("FAIL rm_byte: got %0h, expected 0", bus.byte_out); end
    #10 reset = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_checks++; if (acc_b.size() - b0 !== 5) begin n_errors++; $display("FAIL rm_nbytes: got %0d, expected 5", acc_b.size() - b0); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bq(b0 + i) !== e[i]) begin n_errors++; $display("FAIL rm_byte%0d: got %0h, expected %0h", i, bq(b0 + i), e[i]); end
    end
    for (int i = b0; i < acc_b.size(); i++) if (acc_b[i] == 8'h03 || acc_b[i] == 8'h04) stray++;
    n_checks++; if (stray !== 0) begin n_errors++; $display("FAIL rm_discarded: got %0d stray bytes, expected 0", stray); end
    n_checks++; if (pop_c.size() - p0 !== 2) begin n_errors++; $display("FAIL rm_pops: got %0d, expected 2", pop_c.size() - p0); end
    n_checks++; if (words_sent !== 2'd1) begin n_errors++; $display("FAIL rm_words_after: got %0d, expected 1", words_sent); end
  endtask

  task automatic test_empty_wrap();
    int p0, b0;
    int got = 0;
    logic [CW-1:0] ew [1:5];
    ew = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    enable = 1'b1;
    p0 = pop_c.size();
    b0 = acc_b.size();
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (bus.fifo_get !== 1'b0) got++;
    end
    n_checks++; if (got !== 0) begin n_errors++; $display("FAIL empty_get: got %0d cycles with get, expected 0", got); end
    n_checks++; if (pop_c.size() - p0 !== 0) begin n_errors++; $display("FAIL empty_pops: got %0d, expected 0", pop_c.size() - p0); end
    for (int k = 1; k <= 5; k++) begin
      push(32'hC0DE0000 + WW'(k));
      repeat (8) @(posedge clk); #1;
      n_checks++; if (words_sent !== ew[k]) begin n_errors++; $display("FAIL wrap_words%0d: got %0d, expected %0d", k, words_sent, ew[k]); end
      n_checks++; if (bq(b0 + 4 * k - 1) !== 8'(k)) begin n_errors++; $display("FAIL wrap_lastbyte%0d: got %0h, expected %0h", k, bq(b0 + 4 * k - 1), k); end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wrap_busy: got %0b, expected 0", busy); end
  endtask

  initial begin
    bus.byte_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_empty_wrap();
    n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL protocol: got %0d violations, expected 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
